// File: rtl/run_seq_pkg.sv
// Shared definitions for the run sequencer slice.
// Contents: the sequencer state encoding, the HALT opcode that the decoder and
// Control also use, default parameter values, and a helper that sizes the
// shared phase timer.
// No ports (package).
package run_seq_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RST   = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    // 9-bit instruction encoding of HALT.
    localparam logic [8:0] HALT_OPCODE = 9'b111_111_111;

    localparam int DEF_CW           = 16;
    localparam int DEF_RST_CYCLES   = 2;
    localparam int DEF_DRAIN_CYCLES = 1;
    localparam int DEF_WD_LIMIT     = 4096;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // The timer is loaded with (cycles - 1); wide enough for the largest phase.
    function automatic int timer_width(input int rst_c, input int drain_c, input int wd);
        return $clog2(max3(rst_c, drain_c, wd) + 1);
    endfunction

endpackage

// File: rtl/run_sequencer_if.sv
// Host/core handshake bundle of the run sequencer.
// Signals:
//   req          host -> seq   four-phase start request
//   halt_dec     core -> seq   decoder sees the HALT opcode
//   core_reset   seq  -> core  reset for PC, Register_Mapper, reg_file
//   core_en      seq  -> core  PC advance / write qualifier
//   busy, done, timeout, cycle_count   seq -> host status
// Modports: master (host/core side), slave (sequencer side).
interface run_sequencer_if
    import run_seq_pkg::*;
#(
    parameter int CW = DEF_CW
);
    logic          req;
    logic          halt_dec;
    logic          core_reset;
    logic          core_en;
    logic          busy;
    logic          done;
    logic          timeout;
    logic [CW-1:0] cycle_count;

    modport master (
        output req, halt_dec,
        input  core_reset, core_en, busy, done, timeout, cycle_count
    );

    modport slave (
        input  req, halt_dec,
        output core_reset, core_en, busy, done, timeout, cycle_count
    );
endinterface

// File: rtl/seq_down_timer.sv
// Loadable down-counter with a zero flag. Shared by the RST and DRAIN phases
// and the watchdog of run_sequencer. It stops at zero.
// Ports:
//   clk, reset   clock, asynchronous active-high reset (count -> 0)
//   i_load       load i_load_val this cycle (wins over counting)
//   i_load_val   value to load
//   o_zero       count is zero
module seq_down_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_zero
);
    logic [W-1:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);
endmodule

// File: rtl/run_sequencer.sv
// Start/stop controller for the 9-bit-instruction core. Converts the host
// req/done four-phase handshake into core sequencing: core held in reset while
// idle, released for a run, stopped on HALT, drained, then done raised.
// Keeps a saturating count of RUN-state cycles.
// Optional feature: define RUN_SEQ_WATCHDOG_EN to end runs that stay in RUN
// for WD_LIMIT cycles (timeout=1); otherwise timeout is tied low.
// Ports:
//   clk    core clock
//   reset  asynchronous active-high reset, aborts any run
//   bus    run_sequencer_if.slave (req, halt_dec in; core_reset, core_en,
//          busy, done, timeout, cycle_count out)
module run_sequencer
    import run_seq_pkg::*;
#(
    parameter int CW           = DEF_CW,
    parameter int RST_CYCLES   = DEF_RST_CYCLES,
    parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES,
    parameter int WD_LIMIT     = DEF_WD_LIMIT
) (
    input logic            clk,
    input logic            reset,
    run_sequencer_if.slave bus
);
    localparam int TW = timer_width(RST_CYCLES, DRAIN_CYCLES, WD_LIMIT);
    localparam logic [TW-1:0] RST_LOAD   = TW'(RST_CYCLES - 1);
    localparam logic [TW-1:0] DRAIN_LOAD = TW'(DRAIN_CYCLES - 1);
`ifdef RUN_SEQ_WATCHDOG_EN
    localparam logic [TW-1:0] WD_LOAD    = TW'(WD_LIMIT - 1);
`endif

    state_t        r_state;
    state_t        w_next;
    logic          w_load;
    logic [TW-1:0] w_load_val;
    logic          w_timer_zero;
    logic          w_start;
    logic          r_armed;
    logic [CW-1:0] r_cycle_count;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    seq_down_timer #(.W(TW)) u_timer (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_zero     (w_timer_zero)
    );

    // r_armed: req was sampled low while idle, so a high req is a fresh request
    // and not a leftover from the previous run's handshake.
    assign w_start = (r_state == IDLE) && bus.req && r_armed;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_armed <= 1'b0;
        end else begin
            r_state <= w_next;
            r_armed <= (r_state == IDLE) && !bus.req;
        end
    end

`ifdef RUN_SEQ_WATCHDOG_EN
    logic w_wd_trip;
`endif

    always_comb begin
        w_next     = r_state;
        w_load     = 1'b0;
        w_load_val = '0;
`ifdef RUN_SEQ_WATCHDOG_EN
        w_wd_trip  = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_next     = RST;
                    w_load     = 1'b1;
                    w_load_val = RST_LOAD;
                end
            end
            RST: begin
                // halt_dec is ignored here: decode during reset is stale.
                if (w_timer_zero) begin
                    w_next = RUN;
`ifdef RUN_SEQ_WATCHDOG_EN
                    w_load     = 1'b1;
                    w_load_val = WD_LOAD;
`endif
                end
            end
            RUN: begin
                if (bus.halt_dec) begin
                    w_next     = DRAIN;
                    w_load     = 1'b1;
                    w_load_val = DRAIN_LOAD;
`ifdef RUN_SEQ_WATCHDOG_EN
                end else if (w_timer_zero) begin
                    w_next     = DRAIN;
                    w_load     = 1'b1;
                    w_load_val = DRAIN_LOAD;
                    w_wd_trip  = 1'b1;
`endif
                end
            end
            DRAIN: begin
                if (w_timer_zero) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                if (!bus.req) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // The HALT cycle itself is not counted; a watchdog-ending cycle is.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cycle_count <= '0;
        end else if (w_start) begin
            r_cycle_count <= '0;
        end else if ((r_state == RUN) && !bus.halt_dec) begin
            r_cycle_count <= sat_inc(r_cycle_count);
        end
    end

`ifdef RUN_SEQ_WATCHDOG_EN
    logic r_timeout;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_timeout <= 1'b0;
        end else if (w_start) begin
            r_timeout <= 1'b0;
        end else if (w_wd_trip) begin
            r_timeout <= 1'b1;
        end
    end

    assign bus.timeout = r_timeout;
`else
    assign bus.timeout = 1'b0;
`endif

    // Outputs decode the registered state directly.
    assign bus.core_reset  = (r_state == IDLE) || (r_state == RST);
    assign bus.core_en     = (r_state == RUN);
    assign bus.busy        = (r_state == RST) || (r_state == RUN) || (r_state == DRAIN);
    assign bus.done        = (r_state == DONE);
    assign bus.cycle_count = r_cycle_count;
endmodule

// File: tb/tb_run_sequencer.sv
// Self-checking bench for run_sequencer: three instances (default, CW=4,
// WD_LIMIT=8) share one stimulus; expected waveforms come from a per-run
// timeline computed from the start edge, halt edge and req-drop edge.
module tb_run_sequencer;
    localparam int RSTC = 2;
    localparam int DRC  = 1;
    localparam int NDUT = 3;
`ifdef RUN_SEQ_WATCHDOG_EN
    localparam bit WD_EN = 1'b1;
`else
    localparam bit WD_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic req;
    logic halt;

    always #5 clk = ~clk;

    run_sequencer_if #(.CW(16)) bus0 ();
    run_sequencer_if #(.CW(4))  bus1 ();
    run_sequencer_if #(.CW(16)) bus2 ();

    assign bus0.req = req;  assign bus0.halt_dec = halt;
    assign bus1.req = req;  assign bus1.halt_dec = halt;
    assign bus2.req = req;  assign bus2.halt_dec = halt;

    run_sequencer #(.CW(16), .RST_CYCLES(RSTC), .DRAIN_CYCLES(DRC), .WD_LIMIT(4096))
        dut0 (.clk(clk), .reset(reset), .bus(bus0));
    run_sequencer #(.CW(4), .RST_CYCLES(RSTC), .DRAIN_CYCLES(DRC), .WD_LIMIT(4096))
        dut1 (.clk(clk), .reset(reset), .bus(bus1));
    run_sequencer #(.CW(16), .RST_CYCLES(RSTC), .DRAIN_CYCLES(DRC), .WD_LIMIT(8))
        dut2 (.clk(clk), .reset(reset), .bus(bus2));

    int n_pass   = 0;
    int n_checks = 0;
    int n_fail   = 0;
    int last_cnt[NDUT];
    int last_to[NDUT];

    function automatic int cw_of(input int i);
        return (i == 1) ? 4 : 16;
    endfunction

    function automatic int wd_of(input int i);
        return (i == 2) ? 8 : 4096;
    endfunction

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic get_obs(input int i, output logic crst, output logic cen, output logic bsy,
                           output logic dn, output logic to, output logic [31:0] cnt);
        case (i)
            0: begin crst = bus0.core_reset; cen = bus0.core_en; bsy = bus0.busy;
                     dn = bus0.done; to = bus0.timeout; cnt = 32'(bus0.cycle_count); end
            1: begin crst = bus1.core_reset; cen = bus1.core_en; bsy = bus1.busy;
                     dn = bus1.done; to = bus1.timeout; cnt = 32'(bus1.cycle_count); end
            default: begin crst = bus2.core_reset; cen = bus2.core_en; bsy = bus2.busy;
                     dn = bus2.done; to = bus2.timeout; cnt = 32'(bus2.cycle_count); end
        endcase
    endtask

    task automatic check_dut(input int i, input string ph, input bit e_crst, input bit e_en,
                             input bit e_busy, input bit e_done, input bit e_to, input int e_cnt);
        logic crst, cen, bsy, dn, to;
        logic [31:0] cnt;
        get_obs(i, crst, cen, bsy, dn, to, cnt);
        check($sformatf("%s d%0d core_reset", ph, i), 32'(crst), 32'(e_crst));
        check($sformatf("%s d%0d core_en", ph, i), 32'(cen), 32'(e_en));
        check($sformatf("%s d%0d busy", ph, i), 32'(bsy), 32'(e_busy));
        check($sformatf("%s d%0d done", ph, i), 32'(dn), 32'(e_done));
        check($sformatf("%s d%0d timeout", ph, i), 32'(to), 32'(e_to));
        check($sformatf("%s d%0d cycle_count", ph, i), 32'(cnt), 32'(e_cnt));
    endtask

    task automatic check_idle_all(input string ph);
        for (int i = 0; i < NDUT; i++)
            check_dut(i, ph, 1'b1, 1'b0, 1'b0, 1'b0, last_to[i][0], last_cnt[i]);
    endtask

    task automatic step(input bit r, input bit h);
        req  = r;
        halt = h;
        @(posedge clk);
        #1;
    endtask

    // One run. Edge 0 samples req=1 (start). RUN begins after edge RSTC; halt is
    // sampled at edge Hs = RSTC+1+h_idx (h_idx = RUN cycle index). req is high
    // for edges 0..r_len-1. rehigh: after the run req goes high again without a
    // low cycle in IDLE and must not start a run (only valid when all instances
    // finish on the same edge).
    task automatic do_run(input string name, input int h_idx, input int r_len,
                          input bit stale, input bit noise, input bit rehigh);
        int e;
        int hs;
        int kmax;
        int x[NDUT];
        int d[NDUT];
        int f[NDUT];
        int xc[NDUT];
        int sat[NDUT];
        bit wdto[NDUT];
        e    = RSTC;
        hs   = RSTC + 1 + h_idx;
        kmax = 0;
        for (int i = 0; i < NDUT; i++) begin
            sat[i] = (1 << cw_of(i)) - 1;
            if (WD_EN && (e + wd_of(i) < hs)) begin
                x[i] = e + wd_of(i); wdto[i] = 1'b1; xc[i] = x[i];
            end else begin
                x[i] = hs; wdto[i] = 1'b0; xc[i] = hs - 1;
            end
            d[i] = x[i] + DRC;
            f[i] = imax(d[i] + 1, r_len);
            kmax = imax(kmax, f[i]);
        end
        for (int k = 0; k <= kmax; k++) begin
            bit hv;
            hv = (k == hs) || (stale && k <= e) || (noise && k > hs && $urandom_range(0, 1) == 1);
            step(k < r_len, hv);
            for (int i = 0; i < NDUT; i++) begin
                int  ec;
                bit  eto;
                string ph;
                ec  = (k <= e) ? 0 : imin(imin(k, xc[i]) - e, sat[i]);
                eto = wdto[i] && (k >= x[i]);
                ph  = $sformatf("%s k%0d", name, k);
                if (k < e)         check_dut(i, ph, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, ec);
                else if (k < x[i]) check_dut(i, ph, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, ec);
                else if (k < d[i]) check_dut(i, ph, 1'b0, 1'b0, 1'b1, 1'b0, eto, ec);
                else if (k < f[i]) check_dut(i, ph, 1'b0, 1'b0, 1'b0, 1'b1, eto, ec);
                else               check_dut(i, ph, 1'b1, 1'b0, 1'b0, 1'b0, eto, ec);
            end
        end
        for (int i = 0; i < NDUT; i++) begin
            last_cnt[i] = imin(xc[i] - e, sat[i]);
            last_to[i]  = wdto[i] ? 1 : 0;
        end
        if (rehigh) begin
            for (int j = 0; j < 3; j++) begin
                step(1'b1, 1'b0);
                check_idle_all($sformatf("%s rehigh%0d", name, j));
            end
        end
        step(1'b0, 1'b0);
        check_idle_all($sformatf("%s arm", name));
    endtask

    initial begin
        reset = 1'b1;
        req   = 1'b0;
        halt  = 1'b0;
        for (int i = 0; i < NDUT; i++) begin
            last_cnt[i] = 0;
            last_to[i]  = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        check_idle_all("in_reset");
        @(negedge clk);
        reset = 1'b0;
        step(1'b0, 1'b0);
        check_idle_all("post_reset0");
        step(1'b0, 1'b0);
        check_idle_all("post_reset1");

        do_run("basic", 4, 12, 1'b0, 1'b0, 1'b1);
        do_run("req_drop", 6, 4, 1'b0, 1'b1, 1'b1);
        do_run("stale_rst", 3, 1, 1'b1, 1'b0, 1'b0);
        do_run("first_cycle", 0, 2, 1'b0, 1'b0, 1'b1);
        do_run("saturate", 20, 1, 1'b0, 1'b0, 1'b0);
        do_run("long", 30, 40, 1'b0, 1'b1, 1'b0);
        for (int r = 0; r < 6; r++) begin
            int h;
            int rl;
            h  = int'($urandom_range(0, 25));
            rl = int'($urandom_range(1, 35));
            do_run($sformatf("rand%0d", r), h, rl, 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 1'b0);
        end

        // Asynchronous reset in the middle of RUN.
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        check("midrun d0 core_en", 32'(bus0.core_en), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        for (int i = 0; i < NDUT; i++) begin
            last_cnt[i] = 0;
            last_to[i]  = 0;
        end
        check_idle_all("async_reset");
        @(negedge clk);
        reset = 1'b0;
        req   = 1'b0;
        step(1'b0, 1'b0);
        check_idle_all("after_async0");
        step(1'b0, 1'b0);
        check_idle_all("after_async1");
        do_run("final", 5, 3, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
